// File: rtl/weight_stream_mem_pkg.sv
// Shared constants and types for the banked weight memory and its burst streamer.
package weight_stream_mem_pkg;

   localparam int WEIGHT_BRAM_WIDTH = 8;
   localparam int WEIGHT_BRAM_DEPTH = 16;
   localparam int WEIGHT_BANKS      = 4;

   typedef enum logic [1:0] {WS_IDLE, WS_STREAM, WS_DRAIN} wstream_state_t;

   // A single bank still needs a one-bit select so the port never collapses to zero width.
   function automatic int bank_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_stream_mem_if.sv
// Loader write port, burst command port and PE-array beat stream of weight_stream_mem.
interface weight_stream_mem_if
   import weight_stream_mem_pkg::*;
#(
   parameter int DATA_WIDTH = WEIGHT_BRAM_WIDTH,
   parameter int DEPTH      = WEIGHT_BRAM_DEPTH,
   parameter int NUM_BANKS  = WEIGHT_BANKS
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int BANK_WIDTH = bank_bits(NUM_BANKS);
   localparam int BEAT_WIDTH = NUM_BANKS * DATA_WIDTH;

   logic                  wr_en;
   logic [BANK_WIDTH-1:0] wr_bank;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [ADDR_WIDTH:0]   cmd_len;

   logic                  out_valid;
   logic                  out_ready;
   logic [BEAT_WIDTH-1:0] out_data;
   logic                  out_last;

   logic                  busy;
   logic                  parity_err;

   modport master (
      output wr_en, wr_bank, wr_addr, wr_data,
      output cmd_valid, cmd_addr, cmd_len,
      input  cmd_ready,
      input  out_valid, out_data, out_last,
      output out_ready,
      input  busy, parity_err
   );

   modport slave (
      input  wr_en, wr_bank, wr_addr, wr_data,
      input  cmd_valid, cmd_addr, cmd_len,
      output cmd_ready,
      output out_valid, out_data, out_last,
      input  out_ready,
      output busy, parity_err
   );

endinterface

// File: rtl/weight_stream_mem_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with one cycle of latency, read-first.
module ram_dp_sr_sw1 #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we0,
   input  logic [$clog2(DEPTH)-1:0] addr0,
   input  logic [WIDTH-1:0]         wdata0,
   input  logic                     re1,
   input  logic [$clog2(DEPTH)-1:0] addr1,
   output logic [WIDTH-1:0]         rdata1
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_q;

   // Same-address write and read in one cycle returns the word held before the write.
   always_ff @(posedge clk) begin
      if (we0) mem[addr0] <= wdata0;
      if (re1) rd_q <= mem[addr1];
   end

   assign rdata1 = rd_q;

endmodule

// File: rtl/weight_stream_mem.sv
// Banked weight memory streaming bursts of wide beats to the PE array through a 2-entry buffer.
// Define WEIGHT_MEM_PARITY_EN to store an even-parity bit per word and flag mismatches on readout.
module weight_stream_mem
   import weight_stream_mem_pkg::*;
#(
   parameter int DATA_WIDTH = WEIGHT_BRAM_WIDTH,
   parameter int DEPTH      = WEIGHT_BRAM_DEPTH,
   parameter int NUM_BANKS  = WEIGHT_BANKS
) (
   input  logic               clk,
   input  logic               rst,
   weight_stream_mem_if.slave bus
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int BANK_WIDTH = bank_bits(NUM_BANKS);
   localparam int BEAT_WIDTH = NUM_BANKS * DATA_WIDTH;
`ifdef WEIGHT_MEM_PARITY_EN
   localparam int RAM_WIDTH  = DATA_WIDTH + 1;
`else
   localparam int RAM_WIDTH  = DATA_WIDTH;
`endif
   localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

   wstream_state_t        state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic                  vld_p1_q, vld_p1_d;
   logic                  last_p1_q, last_p1_d;
   logic [1:0]            buf_count_q, buf_count_d;
   logic                  buf_rd_q, buf_rd_d;
   logic                  buf_wr_q, buf_wr_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  busy_q, busy_d;
   logic                  parity_err_q, parity_err_d;

   logic [BEAT_WIDTH-1:0] buf_data_q [2];
   logic                  buf_last_q [2];

   logic [RAM_WIDTH-1:0]  ram_rdata [NUM_BANKS];
   logic [BEAT_WIDTH-1:0] rd_beat_p1;

   logic                  out_valid;
   logic                  pop;
   logic                  accept;
   logic                  issue;
   logic                  push;
   logic                  fifo_pop;
   logic [2:0]            occ;
   logic [BEAT_WIDTH-1:0] head_data;
   logic                  head_last;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [RAM_WIDTH-1:0] wdata;
      logic                 we;
`ifdef WEIGHT_MEM_PARITY_EN
      assign wdata = {^bus.wr_data, bus.wr_data};
`else
      assign wdata = bus.wr_data;
`endif
      assign we = bus.wr_en && (bus.wr_bank == BANK_WIDTH'(b));

      ram_dp_sr_sw1 #(
         .WIDTH (RAM_WIDTH),
         .DEPTH (DEPTH)
      ) u_ram (
         .clk    (clk),
         .we0    (we),
         .addr0  (bus.wr_addr),
         .wdata0 (wdata),
         .re1    (issue),
         .addr1  (rd_ptr_q),
         .rdata1 (ram_rdata[b])
      );

      assign rd_beat_p1[b*DATA_WIDTH +: DATA_WIDTH] = ram_rdata[b][DATA_WIDTH-1:0];
   end

   // The RAM output register acts as the in-flight slot: a fresh read can be handed out
   // directly when the buffer is empty, otherwise it is pushed behind the buffered beats.
   always_comb begin
      out_valid = (buf_count_q != 2'd0) || vld_p1_q;
      pop       = out_valid && bus.out_ready;
      accept    = bus.cmd_valid && cmd_ready_q;
      occ       = {1'b0, buf_count_q} + {2'b00, vld_p1_q};
      issue     = (state_q == WS_STREAM) && (remaining_q != '0) &&
                  (occ < (3'd2 + {2'b00, pop}));

      if (buf_count_q != 2'd0) begin
         head_data = buf_data_q[buf_rd_q];
         head_last = buf_last_q[buf_rd_q];
      end else begin
         head_data = rd_beat_p1;
         head_last = last_p1_q;
      end

      push        = vld_p1_q && !((buf_count_q == 2'd0) && pop);
      fifo_pop    = pop && (buf_count_q != 2'd0);
      buf_count_d = buf_count_q + 2'(push) - 2'(fifo_pop);
      buf_wr_d    = buf_wr_q ^ push;
      buf_rd_d    = buf_rd_q ^ fifo_pop;
      vld_p1_d    = issue;
      last_p1_d   = issue && (remaining_q == LEN_ONE);
   end

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      remaining_d = remaining_q;
      case (state_q)
         WS_IDLE: begin
            if (accept) begin
               rd_ptr_d    = bus.cmd_addr;
               remaining_d = bus.cmd_len;
               if (bus.cmd_len != '0) state_d = WS_STREAM;
            end
         end
         WS_STREAM: begin
            if (issue) begin
               rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - LEN_ONE;
               if (remaining_q == LEN_ONE) state_d = WS_DRAIN;
            end
         end
         WS_DRAIN: begin
            if ((buf_count_d == 2'd0) && !vld_p1_d) state_d = WS_IDLE;
         end
         default: state_d = WS_IDLE;
      endcase
      cmd_ready_d = (state_d == WS_IDLE);
      busy_d      = (state_d != WS_IDLE);
   end

`ifdef WEIGHT_MEM_PARITY_EN
   logic par_bad;
   always_comb begin
      par_bad = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) par_bad = par_bad | (^ram_rdata[b]);
   end
   assign parity_err_d = parity_err_q | (vld_p1_q & par_bad);
`else
   assign parity_err_d = 1'b0;
`endif

   // ---- control registers ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= WS_IDLE;
         rd_ptr_q     <= '0;
         remaining_q  <= '0;
         vld_p1_q     <= 1'b0;
         last_p1_q    <= 1'b0;
         buf_count_q  <= 2'd0;
         buf_rd_q     <= 1'b0;
         buf_wr_q     <= 1'b0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         remaining_q  <= remaining_d;
         vld_p1_q     <= vld_p1_d;
         last_p1_q    <= last_p1_d;
         buf_count_q  <= buf_count_d;
         buf_rd_q     <= buf_rd_d;
         buf_wr_q     <= buf_wr_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
         parity_err_q <= parity_err_d;
      end
   end

   // ---- buffer data (gated by the control counters, so no reset needed) ----
   always_ff @(posedge clk) begin
      if (push) begin
         buf_data_q[buf_wr_q] <= rd_beat_p1;
         buf_last_q[buf_wr_q] <= last_p1_q;
      end
   end

   assign bus.out_valid  = out_valid;
   assign bus.out_data   = out_valid ? head_data : '0;
   assign bus.out_last   = out_valid & head_last;
   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.busy       = busy_q;
   assign bus.parity_err = parity_err_q;

endmodule

// File: tb/tb_weight_stream_mem.sv
// Directed bench for weight_stream_mem: timing, wrap, backpressure, read-first, reset abort.
module tb_weight_stream_mem;

   localparam int DW = 8;
   localparam int DP = 16;
   localparam int NB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] model [NB][DP];

   always #5 clk = ~clk;

   weight_stream_mem_if #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_BANKS(NB)) bus ();

   weight_stream_mem #(.DATA_WIDTH(DW), .DEPTH(DP), .NUM_BANKS(NB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_beat(input int a);
      logic [31:0] r;
      for (int b = 0; b < NB; b++) r[b*8 +: 8] = model[b][a % DP];
      return r;
   endfunction

   task automatic wr(input int b, input int a, input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_bank = 2'(b);
      bus.wr_addr = 4'(a);
      bus.wr_data = d;
      cyc();
      bus.wr_en   = 1'b0;
      model[b][a] = d;
   endtask

   task automatic issue_cmd(input int a, input int len);
      bus.cmd_addr  = 4'(a);
      bus.cmd_len   = 5'(len);
      bus.cmd_valid = 1'b1;
      cyc();
      bus.cmd_valid = 1'b0;
   endtask

   // c counts cycles after the accept edge; first beat is due at c=1, last at c=len with ready high.
   task automatic run_burst(input int a, input int len, input logic [3:0] rpat);
      int c = 0;
      int got = 0;
      int first_c = -1;
      int last_c = -1;
      logic stalled = 1'b0;
      logic [31:0] prev = '0;
      issue_cmd(a, len);
      while (got < len && c < 200) begin
         bus.out_ready = rpat[c % 4];
         if (stalled) chk("hold", {bus.out_valid, bus.out_data}, {1'b1, prev});
         if (bus.out_valid && first_c < 0) first_c = c;
         if (bus.out_valid && bus.out_ready) begin
            chk("beat", bus.out_data, exp_beat(a + got));
            chk("last", bus.out_last, (got == len - 1));
            got++;
            last_c = c;
         end
         stalled = bus.out_valid && !bus.out_ready;
         prev    = bus.out_data;
         cyc();
         c++;
      end
      chk("count", got, len);
      chk("first", first_c, 1);
      if (rpat == 4'hF) chk("end", last_c, len);
      chk("idle", {bus.busy, bus.cmd_ready, bus.out_valid}, 3'b010);
      bus.out_ready = 1'b1;
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
      bus.out_ready = 1'b1;

      repeat (3) cyc();
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_last", bus.out_last, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_perr", bus.parity_err, 0);
      rst = 1'b0;
      cyc();
      chk("rst_ready", bus.cmd_ready, 1);

      for (int b = 0; b < NB; b++)
         for (int a = 0; a < DP; a++) wr(b, a, 8'((b << 4) | a));

      run_burst(10, 4, 4'hF);
      run_burst(14, 4, 4'hF);
      run_burst(0, 8, 4'b1001);

      // Write to the word being read in the same cycle: read must see the old value.
      wr(1, 5, 8'hAA);
      issue_cmd(5, 1);
      bus.wr_en = 1'b1; bus.wr_bank = 2'd1; bus.wr_addr = 4'd5; bus.wr_data = 8'h55;
      cyc();
      bus.wr_en = 1'b0;
      chk("rf_valid", bus.out_valid, 1);
      chk("rf_lane1", bus.out_data[15:8], 8'hAA);
      chk("rf_beat", bus.out_data, exp_beat(5));
      model[1][5] = 8'h55;
      cyc();
      run_burst(5, 1, 4'hF);

      issue_cmd(3, 0);
      for (int i = 0; i < 3; i++) begin
         chk("len0_valid", bus.out_valid, 0);
         chk("len0_ready", bus.cmd_ready, 1);
         cyc();
      end

      issue_cmd(0, 8);
      repeat (3) cyc();
      chk("ab_beat3", {bus.out_valid, bus.out_data}, {1'b1, exp_beat(2)});
      rst = 1'b1;
      #1;
      chk("ab_valid", bus.out_valid, 0);
      chk("ab_busy", bus.busy, 0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("ab_after", {bus.out_valid, bus.cmd_ready}, 2'b01);
      run_burst(3, 4, 4'hF);

`ifdef WEIGHT_MEM_PARITY_EN
      chk("perr_clean", bus.parity_err, 0);
      dut.g_bank[2].u_ram.mem[7][0] = ~dut.g_bank[2].u_ram.mem[7][0];
      model[2][7][0] = ~model[2][7][0];
      run_burst(7, 1, 4'hF);
      chk("perr_set", bus.parity_err, 1);
      cyc();
      chk("perr_held", bus.parity_err, 1);
`else
      chk("perr_off", bus.parity_err, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
